// File: rtl/sdram_cmd_responder.sv
// Block-RAM backed responder for the SDRAM controller command interface.
// Define SDRAM_CMD_RESPONDER_STALL_EN to emulate periodic refresh backpressure on cmdReady.
module sdram_cmd_responder #(
  parameter int unsigned AddrWidth       = 25,
  parameter int unsigned DataWidth       = 16,
  parameter int unsigned DepthLog2       = 12,
  parameter int unsigned ReadLatency     = 3,
  parameter int unsigned RefreshInterval = 64,
  parameter int unsigned RefreshStall    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 cmdReady,
  input  logic                 cmdTrigger,
  input  logic [AddrWidth-1:0] cmdAddr,
  input  logic                 cmdWrite,
  input  logic [DataWidth-1:0] cmdWriteData,
  output logic [DataWidth-1:0] cmdReadData,
  output logic                 cmdReadDataValid
);

  if (ReadLatency < 1 || ReadLatency > 8) begin : g_bad_latency
    $error("sdram_cmd_responder: ReadLatency must be within 1..8");
  end
  if (DepthLog2 > AddrWidth) begin : g_bad_depth
    $error("sdram_cmd_responder: DepthLog2 must not exceed AddrWidth");
  end
  if (RefreshInterval < 2 || RefreshStall < 1) begin : g_bad_refresh
    $error("sdram_cmd_responder: RefreshInterval >= 2 and RefreshStall >= 1 required");
  end

  logic [DataWidth-1:0] mem [0:(1 << DepthLog2)-1];
  logic [DepthLog2-1:0] word_addr;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 unused_addr;

  // Upper address bits are deliberately ignored so the RAM aliases across the space.
  assign unused_addr = ^cmdAddr;
  assign word_addr   = cmdAddr[DepthLog2-1:0];

  always_comb begin
    wr_accept = cmdTrigger && cmdReady && !rst && cmdWrite;
    rd_accept = cmdTrigger && cmdReady && !rst && !cmdWrite;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[word_addr] <= cmdWriteData;
  end

  // Stage 0 is the synchronous RAM read; data registers only load on a valid
  // beat so the last returned word is held on cmdReadData between strobes.
  logic [ReadLatency-1:0] pipe_valid;
  logic [DataWidth-1:0]   pipe_data [ReadLatency];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < ReadLatency; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      if (rd_accept) pipe_data[0] <= mem[word_addr];
      for (int unsigned i = 1; i < ReadLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_comb begin
    cmdReadDataValid = pipe_valid[ReadLatency-1];
    cmdReadData      = pipe_data[ReadLatency-1];
  end

`ifdef SDRAM_CMD_RESPONDER_STALL_EN
  localparam int unsigned RdyW = $clog2(RefreshInterval);
  localparam int unsigned StlW = (RefreshStall > 1) ? $clog2(RefreshStall) : 1;
  localparam logic [RdyW-1:0] RdyLast = RdyW'(RefreshInterval - 1);
  localparam logic [StlW-1:0] StlLast = StlW'(RefreshStall - 1);

  typedef enum logic {READY, STALL} state_t;

  state_t          state;
  logic [RdyW-1:0] ready_cnt;
  logic [StlW-1:0] stall_cnt;

  // Only cycles with cmdReady high count toward the interval, so the period is
  // exactly RefreshInterval ready cycles followed by RefreshStall stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= READY;
      cmdReady  <= 1'b0;
      ready_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        READY: begin
          if (!cmdReady) begin
            cmdReady <= 1'b1;
          end else if (ready_cnt == RdyLast) begin
            state     <= STALL;
            cmdReady  <= 1'b0;
            ready_cnt <= '0;
            stall_cnt <= '0;
          end else begin
            ready_cnt <= ready_cnt + RdyW'(1);
          end
        end
        STALL: begin
          if (stall_cnt == StlLast) begin
            state     <= READY;
            cmdReady  <= 1'b1;
            ready_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + StlW'(1);
          end
        end
        default: begin
          state    <= READY;
          cmdReady <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) cmdReady <= 1'b0;
    else     cmdReady <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed self-checking bench for sdram_cmd_responder (default parameters, ReadLatency 3).
module tb_sdram_cmd_responder;
  localparam int unsigned RL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdReady;
  logic        cmdTrigger;
  logic [24:0] cmdAddr;
  logic        cmdWrite;
  logic [15:0] cmdWriteData;
  logic [15:0] cmdReadData;
  logic        cmdReadDataValid;

  int assertions = 0;
  int failures   = 0;

  sdram_cmd_responder #(
    .AddrWidth(25), .DataWidth(16), .DepthLog2(12), .ReadLatency(RL),
    .RefreshInterval(64), .RefreshStall(4)
  ) dut (
    .clk(clk), .rst(rst), .cmdReady(cmdReady), .cmdTrigger(cmdTrigger),
    .cmdAddr(cmdAddr), .cmdWrite(cmdWrite), .cmdWriteData(cmdWriteData),
    .cmdReadData(cmdReadData), .cmdReadDataValid(cmdReadDataValid)
  );

  always #5 clk = ~clk;

  // Edge counter plus logs of read accepts and returned strobes, sampled mid-cycle.
  int unsigned cyc = 0;
  int unsigned rd_acc_cyc[$];
  int unsigned strobe_cyc[$];
  logic [15:0] strobe_data[$];
  int unsigned acc_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmdReadDataValid === 1'b1) begin
      strobe_data.push_back(cmdReadData);
      strobe_cyc.push_back(cyc);
    end
    if (cmdTrigger && cmdReady === 1'b1 && !rst) begin
      acc_count++;
      if (!cmdWrite) rd_acc_cyc.push_back(cyc + 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_acc_cyc.delete();
    strobe_cyc.delete();
    strobe_data.delete();
    acc_count = 0;
  endtask

  task automatic idle();
    cmdTrigger = 1'b0;
    cmdWrite   = 1'b0;
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Presents one command and returns #1 after the edge that accepts it.
  task automatic issue(input logic wr, input logic [24:0] a, input logic [15:0] d);
    logic ok;
    logic done;
    done = 1'b0;
    cmdTrigger = 1'b1; cmdWrite = wr; cmdAddr = a; cmdWriteData = d;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      ok = cmdReady;
      @(posedge clk);
      #1;
      if (ok === 1'b1) done = 1'b1;
    end
    if (!done) begin
      assertions++; failures++;
      $display("FAIL issue_timeout: addr=%h not accepted within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); cmdAddr = '0; cmdWriteData = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    assertions++;
    if (cmdReady !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", cmdReady); end
    assertions++;
    if (cmdReadDataValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", cmdReadDataValid); end
    assertions++;
    if (cmdReadData !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h want 0000", cmdReadData); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    assertions++;
    if (cmdReady !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", cmdReady); end
  endtask

  task automatic test_write_read_cafe();
    clear_logs();
    for (int i = 0; i < 16; i++) issue(1'b1, 25'(i), 16'hCAFE);
    for (int i = 0; i < 16; i++) issue(1'b0, 25'(i), 16'h0000);
    idle();
    drain();
    assertions++;
    if (strobe_data.size() != 16) begin failures++; $display("FAIL cafe_count: got %0d want 16", strobe_data.size()); end
    for (int n = 0; n < 16; n++) begin
      if (n < strobe_data.size() && n < rd_acc_cyc.size()) begin
        assertions++;
        if (strobe_data[n] !== 16'hCAFE) begin
          failures++; $display("FAIL cafe_data[%0d]: got %h want cafe", n, strobe_data[n]);
        end
        assertions++;
        if (strobe_cyc[n] != rd_acc_cyc[n] + RL - 1) begin
          failures++;
          $display("FAIL cafe_latency[%0d]: valid after edge %0d want after edge %0d", n, strobe_cyc[n], rd_acc_cyc[n] + RL - 1);
        end
      end
    end
`ifndef SDRAM_CMD_RESPONDER_STALL_EN
    assertions++;
    if (rd_acc_cyc.size() != 16 || rd_acc_cyc[15] != rd_acc_cyc[0] + 15) begin
      failures++; $display("FAIL cafe_back_to_back: read accepts not on 16 consecutive edges (count %0d)", rd_acc_cyc.size());
    end
`endif
    assertions++;
    if (cmdReadDataValid !== 1'b0 || cmdReadData !== 16'hCAFE) begin
      failures++; $display("FAIL hold_data: got valid=%b data=%h want valid=0 data=cafe", cmdReadDataValid, cmdReadData);
    end
  endtask

  task automatic test_stream_256();
    clear_logs();
    for (int i = 0; i < 256; i++) issue(1'b1, 25'(i), 16'(i));
    for (int i = 0; i < 256; i++) issue(1'b0, 25'(i), 16'h0000);
    idle();
    drain();
    assertions++;
    if (strobe_data.size() != 256) begin failures++; $display("FAIL stream_count: got %0d want 256", strobe_data.size()); end
    for (int n = 0; n < 256; n++) begin
      if (n < strobe_data.size() && n < rd_acc_cyc.size()) begin
        assertions++;
        if (strobe_data[n] !== 16'(n) || strobe_cyc[n] != rd_acc_cyc[n] + RL - 1) begin
          failures++;
          $display("FAIL stream[%0d]: got %h at edge %0d want %h at edge %0d", n, strobe_data[n], strobe_cyc[n], 16'(n), rd_acc_cyc[n] + RL - 1);
        end
      end
    end
  endtask

  task automatic test_alias_raw();
    clear_logs();
    issue(1'b1, 25'h1000, 16'h1234);
    issue(1'b0, 25'h0000, 16'h0000);
    issue(1'b1, 25'h0005, 16'hBEEF);
    issue(1'b0, 25'h0005, 16'h0000);
    idle();
    drain();
    assertions++;
    if (strobe_data.size() != 2) begin failures++; $display("FAIL alias_count: got %0d want 2", strobe_data.size()); end
    if (strobe_data.size() == 2) begin
      assertions++;
      if (strobe_data[0] !== 16'h1234) begin failures++; $display("FAIL alias_data: got %h want 1234", strobe_data[0]); end
      assertions++;
      if (strobe_data[1] !== 16'hBEEF) begin failures++; $display("FAIL raw_data: got %h want beef", strobe_data[1]); end
    end
  endtask

  task automatic test_reset_mid_read();
    clear_logs();
    issue(1'b0, 25'h0001, 16'h0000);
    issue(1'b0, 25'h0002, 16'h0000);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    assertions++;
    if (cmdReady !== 1'b0 || cmdReadData !== 16'h0000) begin
      failures++; $display("FAIL midrst_first: got ready=%b data=%h want ready=0 data=0000", cmdReady, cmdReadData);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (cmdReady !== 1'b0 || cmdReadData !== 16'h0000) begin
      failures++; $display("FAIL midrst_second: got ready=%b data=%h want ready=0 data=0000", cmdReady, cmdReadData);
    end
    @(posedge clk); #1;
    assertions++;
    if (cmdReady !== 1'b1) begin failures++; $display("FAIL midrst_release_ready: got %b want 1", cmdReady); end
    drain();
    assertions++;
    if (strobe_data.size() != 0) begin failures++; $display("FAIL midrst_no_strobe: got %0d strobes want 0", strobe_data.size()); end
  endtask

`ifdef SDRAM_CMD_RESPONDER_STALL_EN
  task automatic test_refresh_stall();
    int bad;
    int lows;
    bad = 0; lows = 0;
    rst = 1'b1; idle();
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst = 1'b0;
    cmdTrigger = 1'b1; cmdWrite = 1'b0; cmdAddr = 25'h0003;
    @(posedge clk); #1;
    for (int i = 0; i < 680; i++) begin
      @(negedge clk);
      if (cmdReady !== ((i % 68) < 64)) bad++;
      if (cmdReady !== 1'b1) lows++;
    end
    @(posedge clk); #1;
    idle();
    drain();
    assertions++;
    if (bad != 0) begin failures++; $display("FAIL stall_pattern: got %0d misplaced cycles want 0", bad); end
    assertions++;
    if (lows != 40) begin failures++; $display("FAIL stall_low_cycles: got %0d want 40", lows); end
    assertions++;
    if (acc_count != 640) begin failures++; $display("FAIL stall_accepts: got %0d want 640", acc_count); end
    assertions++;
    if (strobe_data.size() != 640) begin failures++; $display("FAIL stall_strobes: got %0d want 640", strobe_data.size()); end
  endtask
`else
  task automatic test_ready_always();
    int drops;
    drops = 0;
    clear_logs();
    for (int i = 0; i < 1000; i++) begin
      cmdTrigger   = (i >= 500);
      cmdWrite     = (i % 2 == 0);
      cmdAddr      = 25'(i & ~1);
      cmdWriteData = 16'(i & ~1);
      @(negedge clk);
      if (cmdReady !== 1'b1) drops++;
      @(posedge clk); #1;
    end
    idle();
    drain();
    assertions++;
    if (drops != 0) begin failures++; $display("FAIL ready_drops: got %0d want 0", drops); end
    assertions++;
    if (acc_count != 500) begin failures++; $display("FAIL ready_accepts: got %0d want 500", acc_count); end
    assertions++;
    if (strobe_data.size() != 250) begin failures++; $display("FAIL ready_strobes: got %0d want 250", strobe_data.size()); end
    for (int n = 0; n < 250; n++) begin
      if (n < strobe_data.size()) begin
        assertions++;
        if (strobe_data[n] !== 16'(500 + 2 * n)) begin
          failures++; $display("FAIL ready_data[%0d]: got %h want %h", n, strobe_data[n], 16'(500 + 2 * n));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read_cafe();
    test_stream_256();
    test_alias_raw();
    test_reset_mid_read();
`ifdef SDRAM_CMD_RESPONDER_STALL_EN
    test_refresh_stall();
`else
    test_ready_always();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
